// File: rtl/post_state_serial.sv
// Kalman measurement update: y = z - H*x, x_post = x + K*y, one shared multiplier.
// Define POST_STATE_SAT_EN to saturate the N+2 -> N reductions instead of wrapping.
module post_state_serial #(
  parameter int N    = 20,
  parameter int FRAC = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [N-1:0] x00,
  input  logic signed [N-1:0] x10,
  input  logic signed [N-1:0] z00,
  input  logic signed [N-1:0] z10,
  input  logic signed [N-1:0] h00,
  input  logic signed [N-1:0] h01,
  input  logic signed [N-1:0] h10,
  input  logic signed [N-1:0] h11,
  input  logic signed [N-1:0] k00,
  input  logic signed [N-1:0] k01,
  input  logic signed [N-1:0] k10,
  input  logic signed [N-1:0] k11,
  output logic                busy,
  output logic                done,
  output logic signed [N-1:0] Y00,
  output logic signed [N-1:0] Y10,
  output logic signed [N-1:0] X_POST00,
  output logic signed [N-1:0] X_POST10
);

  typedef enum logic [2:0] {
    S_IDLE, S_HX, S_INNOV, S_KY, S_FIN
  } state_t;

  state_t r_state, w_next;
  logic [1:0] r_step;
  logic signed [N-1:0] r_x0, r_x1, r_z0, r_z1;
  logic signed [N-1:0] r_h00, r_h01, r_h10, r_h11;
  logic signed [N-1:0] r_k00, r_k01, r_k10, r_k11;
  logic signed [N-1:0] r_y0, r_y1;
  logic signed [N+1:0] r_acc0, r_acc1;
  logic signed [N-1:0] r_Y00, r_Y10, r_XP0, r_XP1;
  logic                r_done;

  logic signed [N-1:0]   w_ma, w_mb, w_pn;
  logic signed [2*N-1:0] w_prod;
  logic signed [N+1:0]   w_term;

  function automatic logic signed [N-1:0] f_reduce(
    input logic signed [N+1:0] v
  );
`ifdef POST_STATE_SAT_EN
    logic signed [N+1:0] lo, hi;
    hi = {3'b000, {(N-1){1'b1}}};
    lo = {3'b111, {(N-1){1'b0}}};
    if (v > hi) return hi[N-1:0];
    else if (v < lo) return lo[N-1:0];
    else return N'(v);
`else
    return N'(v);
`endif
  endfunction

  // Operand select: step[1] picks the row, step[0] the column.
  always_comb begin
    w_ma = '0;
    w_mb = '0;
    if (r_state == S_HX) begin
      unique case (r_step)
        2'd0: w_ma = r_h00;
        2'd1: w_ma = r_h01;
        2'd2: w_ma = r_h10;
        default: w_ma = r_h11;
      endcase
      w_mb = r_step[0] ? r_x1 : r_x0;
    end else if (r_state == S_KY) begin
      unique case (r_step)
        2'd0: w_ma = r_k00;
        2'd1: w_ma = r_k01;
        2'd2: w_ma = r_k10;
        default: w_ma = r_k11;
      endcase
      w_mb = r_step[0] ? r_y1 : r_y0;
    end
  end

  assign w_prod = (2*N)'(w_ma) * (2*N)'(w_mb);
  assign w_pn   = N'(w_prod >>> FRAC);
  assign w_term = (N+2)'(w_pn);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_HX;
      S_HX:    if (r_step == 2'd3) w_next = S_INNOV;
      S_INNOV: w_next = S_KY;
      S_KY:    if (r_step == 2'd3) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= '0;
      r_x0 <= '0; r_x1 <= '0; r_z0 <= '0; r_z1 <= '0;
      r_h00 <= '0; r_h01 <= '0; r_h10 <= '0; r_h11 <= '0;
      r_k00 <= '0; r_k01 <= '0; r_k10 <= '0; r_k11 <= '0;
      r_y0 <= '0; r_y1 <= '0;
      r_acc0 <= '0; r_acc1 <= '0;
      r_Y00 <= '0; r_Y10 <= '0; r_XP0 <= '0; r_XP1 <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: if (start) begin
          r_x0 <= x00; r_x1 <= x10; r_z0 <= z00; r_z1 <= z10;
          r_h00 <= h00; r_h01 <= h01; r_h10 <= h10; r_h11 <= h11;
          r_k00 <= k00; r_k01 <= k01; r_k10 <= k10; r_k11 <= k11;
          r_step <= '0;
          r_acc0 <= '0;
          r_acc1 <= '0;
        end
        S_HX, S_KY: begin
          if (!r_step[1]) r_acc0 <= r_acc0 + w_term;
          else            r_acc1 <= r_acc1 + w_term;
          r_step <= r_step + 2'd1;
        end
        S_INNOV: begin
          r_y0   <= f_reduce((N+2)'(r_z0) - r_acc0);
          r_y1   <= f_reduce((N+2)'(r_z1) - r_acc1);
          r_acc0 <= (N+2)'(r_x0);
          r_acc1 <= (N+2)'(r_x1);
          r_step <= '0;
        end
        S_FIN: begin
          r_Y00  <= r_y0;
          r_Y10  <= r_y1;
          r_XP0  <= f_reduce(r_acc0);
          r_XP1  <= f_reduce(r_acc1);
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign Y00      = r_Y00;
  assign Y10      = r_Y10;
  assign X_POST00 = r_XP0;
  assign X_POST10 = r_XP1;

endmodule
